// File: rtl/crumb_div_seq.sv
// crumb_div_seq: sequential restoring divider for the Vedic divider path.
// Dividend is crumb-encoded on accept and consumed one crumb per cycle.
module crumb_div_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     quotient,
    output logic [2*WIDTH-1:0]   quotient_crumb,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero,
    output logic                 busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ENCODE,
        ITER,
        DONE
    } state_e;

    state_e               state_q;
    logic [2*WIDTH-1:0]   crumb_q;
    logic [WIDTH-1:0]     div_q;
    logic [WIDTH-1:0]     rem_q;
    logic [WIDTH-1:0]     quo_q;
    logic [CW-1:0]        cnt_q;

    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 busy_q;
    logic                 dbz_q;
    logic [WIDTH-1:0]     quotient_q;
    logic [WIDTH-1:0]     remainder_q;
    logic [2*WIDTH-1:0]   qcrumb_q;

    logic                 d_bit;
    logic [WIDTH:0]       r_shift_d;
    logic                 ge_d;
    logic [WIDTH-1:0]     r_diff_d;
    logic [WIDTH-1:0]     rem_d;
    logic [WIDTH-1:0]     quo_d;
    logic [2*WIDTH-1:0]   crumb_d;
    logic                 odd_any;

    // Each bit becomes a crumb {0, bit}.
    function automatic logic [2*WIDTH-1:0] crumb_enc(input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c[2*i] = b[i];
        end
        return c;
    endfunction

    // Low bit of each crumb carries the data; the high bit is ignored.
    function automatic logic [WIDTH-1:0] crumb_dec(input logic [2*WIDTH-1:0] c);
        logic [WIDTH-1:0] b;
        b = '0;
        for (int i = 0; i < WIDTH; i++) begin
            b[i] = c[2*i];
        end
        return b;
    endfunction

    // One restoring shift-subtract step on the top crumb.
    always_comb begin
        d_bit     = crumb_q[2*WIDTH-2];
        r_shift_d = {rem_q, d_bit};
        ge_d      = (r_shift_d >= {1'b0, div_q});
        // When ge_d holds the true difference is < divisor, so the low
        // WIDTH bits of the modular subtraction are exact.
        r_diff_d  = r_shift_d[WIDTH-1:0] - div_q;
        rem_d     = ge_d ? r_diff_d : r_shift_d[WIDTH-1:0];
        quo_d     = {quo_q[WIDTH-2:0], ge_d};
        crumb_d   = {crumb_q[2*WIDTH-3:0], 2'b00};
    end

    // Flag any crumb whose upper bit is set.
    always_comb begin
        odd_any = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            odd_any = odd_any | crumb_q[2*i+1];
        end
    end

    a_legal_crumb: assert property (
        @(posedge clk) disable iff (rst) (state_q == ITER) |-> !odd_any
    );

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            crumb_q     <= '0;
            div_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            qcrumb_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        crumb_q    <= crumb_enc(dividend);
                        div_q      <= divisor;
                        rem_q      <= '0;
                        quo_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ENCODE;
                    end
                end
                ENCODE: begin
                    if (div_q == '0) begin
                        dbz_q       <= 1'b1;
                        quotient_q  <= {WIDTH{1'b1}};
                        qcrumb_q    <= crumb_enc({WIDTH{1'b1}});
                        remainder_q <= crumb_dec(crumb_q);
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q   <= CW'(WIDTH - 1);
                        state_q <= ITER;
                    end
                end
                ITER: begin
                    rem_q   <= rem_d;
                    quo_q   <= quo_d;
                    crumb_q <= crumb_d;
                    cnt_q   <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        dbz_q       <= 1'b0;
                        quotient_q  <= quo_d;
                        qcrumb_q    <= crumb_enc(quo_d);
                        remainder_q <= rem_d;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign busy           = busy_q;
    assign div_by_zero    = dbz_q;
    assign quotient       = quotient_q;
    assign remainder      = remainder_q;
    assign quotient_crumb = qcrumb_q;

endmodule

// File: tb/tb_crumb_div_seq.sv
// tb_crumb_div_seq: directed vector bench for crumb_div_seq.
// Table of operand pairs plus backpressure and mid-run reset sequences.
module tb_crumb_div_seq;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   dividend;
    logic [W-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   quotient;
    logic [2*W-1:0] quotient_crumb;
    logic [W-1:0]   remainder;
    logic           div_by_zero;
    logic           busy;

    int checks;
    int errors;

    typedef struct {
        logic [W-1:0]   dvd;
        logic [W-1:0]   dvs;
        logic [W-1:0]   q;
        logic [2*W-1:0] qc;
        logic [W-1:0]   r;
        logic           dbz;
    } vec_t;

    vec_t vecs[10];

    crumb_div_seq #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .dividend       (dividend),
        .divisor        (divisor),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .quotient       (quotient),
        .quotient_crumb (quotient_crumb),
        .remainder      (remainder),
        .div_by_zero    (div_by_zero),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    // Accept one operand pair; returns after the accept edge (+1).
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
        wait_ready();
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 8'hA5;
        divisor  = 8'h00;
    endtask

    // Count edges until out_valid and busy samples seen on the way.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!out_valid && lat < 40) begin
            if (busy) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic do_op(input vec_t v, input string tag);
        int lat;
        int bcnt;
        int exp_lat;
        exp_lat = v.dbz ? 1 : W + 1;
        out_ready = 1'b1;
        accept(v.dvd, v.dvs);
        wait_done(lat, bcnt);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_busycyc"}, bcnt, exp_lat);
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_q"}, {24'd0, quotient}, {24'd0, v.q});
        chk({tag, "_qc"}, {16'd0, quotient_crumb}, {16'd0, v.qc});
        chk({tag, "_r"}, {24'd0, remainder}, {24'd0, v.r});
        chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, v.dbz});
        chk({tag, "_inrdy_done"}, {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_inrdy_after"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_ov_after"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_q_hold"}, {24'd0, quotient}, {24'd0, v.q});
    endtask

    initial begin
        int lat;
        int bcnt;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;

        vecs[0] = '{8'd200, 8'd7,   8'd28,  16'h0150, 8'd4,   1'b0};
        vecs[1] = '{8'd55,  8'd0,   8'hFF,  16'h5555, 8'd55,  1'b1};
        vecs[2] = '{8'd255, 8'd1,   8'd255, 16'h5555, 8'd0,   1'b0};
        vecs[3] = '{8'd5,   8'd9,   8'd0,   16'h0000, 8'd5,   1'b0};
        vecs[4] = '{8'd0,   8'd5,   8'd0,   16'h0000, 8'd0,   1'b0};
        vecs[5] = '{8'd254, 8'd255, 8'd0,   16'h0000, 8'd254, 1'b0};
        vecs[6] = '{8'd255, 8'd255, 8'd1,   16'h0001, 8'd0,   1'b0};
        vecs[7] = '{8'd128, 8'd3,   8'd42,  16'h0444, 8'd2,   1'b0};
        vecs[8] = '{8'd0,   8'd0,   8'hFF,  16'h5555, 8'd0,   1'b1};
        vecs[9] = '{8'd9,   8'd3,   8'd3,   16'h0005, 8'd0,   1'b0};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_q", {24'd0, quotient}, 32'd0);
        chk("rst_qc", {16'd0, quotient_crumb}, 32'd0);
        chk("rst_r", {24'd0, remainder}, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure on 100/10 with a stray in_valid pulse.
        out_ready = 1'b0;
        accept(8'd100, 8'd10);
        wait_done(lat, bcnt);
        chk("bp_lat", lat, W + 1);
        for (int k = 0; k < 5; k++) begin
            in_valid = (k == 2);
            dividend = 8'd7;
            divisor  = 8'd1;
            @(posedge clk);
            #1;
            chk("bp_ov", {31'd0, out_valid}, 32'd1);
            chk("bp_q", {24'd0, quotient}, 32'd10);
            chk("bp_r", {24'd0, remainder}, 32'd0);
            chk("bp_qc", {16'd0, quotient_crumb}, 32'h0044);
            chk("bp_inrdy", {31'd0, in_ready}, 32'd0);
            chk("bp_busy", {31'd0, busy}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_rel_inrdy", {31'd0, in_ready}, 32'd1);
        chk("bp_rel_ov", {31'd0, out_valid}, 32'd0);
        chk("bp_rel_q", {24'd0, quotient}, 32'd10);
        @(posedge clk);
        #1;
        chk("bp_no_accept", {31'd0, busy}, 32'd0);

        // Reset during the 4th ITER cycle of 200/7.
        accept(8'd200, 8'd7);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_inrdy", {31'd0, in_ready}, 32'd1);
        chk("mid_ov", {31'd0, out_valid}, 32'd0);
        chk("mid_busy0", {31'd0, busy}, 32'd0);
        chk("mid_q", {24'd0, quotient}, 32'd0);
        chk("mid_r", {24'd0, remainder}, 32'd0);
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            chk("mid_no_ov", {31'd0, out_valid}, 32'd0);
        end
        do_op(vecs[9], "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
